// File: rtl/prism_cfg_pkg.sv
// PRISM config sequencer shared types: FSM states, register addresses, write-size codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prism_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [5:0] CFG_LO_ADDR = 6'h08;
  localparam logic [5:0] CFG_HI_ADDR = 6'h0C;

  localparam logic [1:0] DW_8    = 2'b00;
  localparam logic [1:0] DW_16   = 2'b01;
  localparam logic [1:0] DW_32   = 2'b10;
  localparam logic [1:0] DW_NONE = 2'b11;

endpackage

// File: rtl/prism_cfg_sequencer.sv
// Assembles two 32-bit bus writes into a config word and walks one-hot latch enables down the chain.
// Latency: first enable one cycle after the HI write edge; done pulse 2*DEPTH+1 cycles after it.
// Backpressure: none; writes arriving mid-sequence are dropped and flagged in the sticky err bit.
module prism_cfg_sequencer
  import prism_cfg_pkg::*;
#(
  parameter int         DEPTH   = 8,
  parameter int         WIDTH   = 64,
  parameter logic [5:0] LO_ADDR = CFG_LO_ADDR,
  parameter logic [5:0] HI_ADDR = CFG_HI_ADDR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [5:0]               address,
  input  logic [31:0]              data_in,
  input  logic [1:0]               data_write_n,
  input  logic                     clear,
  output logic [WIDTH-1:0]         config_data,
  output logic [DEPTH-1:0]         latch_en,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   load_count
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH) + 1;

  state_t            state, state_nxt;
  logic [IDXW-1:0]   idx, idx_nxt;
  logic              lo_valid;
  logic [DEPTH-1:0]  latch_en_nxt;
  logic              busy_nxt;
  logic              done_nxt;

  logic              wr32;
  logic              lo_wr;
  logic              hi_wr;
  logic              can_accept;
  logic              start;
  logic              seq_err;

  // Write decode: only full 32-bit writes to the two config addresses are meaningful.
  // DONE is not busy, so writes landing on it are accepted exactly as in IDLE.
  always_comb begin
    wr32       = (data_write_n == DW_32);
    lo_wr      = wr32 && (address == LO_ADDR);
    hi_wr      = wr32 && (address == HI_ADDR);
    can_accept = (state == IDLE) || (state == DONE);
    start      = hi_wr && can_accept && lo_valid;
    seq_err    = ((lo_wr || hi_wr) && !can_accept) || (hi_wr && can_accept && !lo_valid);
  end

  // Next-state and next-output decode; outputs are looked up from the next state so they leave flops.
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    latch_en_nxt = '0;
    busy_nxt     = 1'b0;
    done_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = PULSE;
          idx_nxt   = IDXW'(DEPTH - 1);
        end
      end
      PULSE: state_nxt = GAP;
      GAP: begin
        if (idx == '0) begin
          state_nxt = DONE;
        end else begin
          state_nxt = PULSE;
          idx_nxt   = idx - 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          state_nxt = PULSE;
          idx_nxt   = IDXW'(DEPTH - 1);
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt == PULSE) begin
      latch_en_nxt = {{(DEPTH-1){1'b0}}, 1'b1} << idx_nxt;
    end
    busy_nxt = (state_nxt == PULSE) || (state_nxt == GAP);
    done_nxt = (state_nxt == DONE);
  end

  // FSM state, stage index and the registered enable/status outputs; reset kills enables at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      latch_en <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      latch_en <= latch_en_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

  // Word assembly: halves only update outside a sequence, so D inputs are stable under every enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      config_data <= '0;
      lo_valid    <= 1'b0;
    end else begin
      if (lo_wr && can_accept) begin
        config_data[31:0] <= data_in;
      end
      if (start) begin
        config_data[63:32] <= data_in;
      end
      if (clear || start) begin
        lo_valid <= 1'b0;
      end else if (lo_wr && can_accept) begin
        lo_valid <= 1'b1;
      end
    end
  end

  // Status: sticky error and saturating load counter; clear beats both set and increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err        <= 1'b0;
      load_count <= '0;
    end else if (clear) begin
      err        <= 1'b0;
      load_count <= '0;
    end else begin
      if (seq_err) begin
        err <= 1'b1;
      end
      if ((state == DONE) && (load_count != CNTW'(DEPTH))) begin
        load_count <= load_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prism_cfg_sequencer.sv
// Directed bench for prism_cfg_sequencer: table of single-write vectors plus hand sequences.
// Latency: checks sample 1 time unit after the rising edge.
// Backpressure: n/a.
module tb_prism_cfg_sequencer;

  logic        clk;
  logic        rst;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic        clear;
  logic [63:0] config_data;
  logic [7:0]  latch_en;
  logic        busy;
  logic        done;
  logic        err;
  logic [3:0]  load_count;

  int checks = 0;
  int errors = 0;
  logic [7:0] prev_en = '0;

  prism_cfg_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .address      (address),
    .data_in      (data_in),
    .data_write_n (data_write_n),
    .clear        (clear),
    .config_data  (config_data),
    .latch_en     (latch_en),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .load_count   (load_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Enable hygiene: at most one bit set, and never two enabled cycles back to back.
  always @(negedge clk) begin
    if (!rst && latch_en != 8'h00) begin
      checks++;
      if ($countones(latch_en) != 1 || prev_en != 8'h00) begin
        errors++;
        $display("FAIL en_onehot_gap got %h prev %h", latch_en, prev_en);
      end
    end
    prev_en = latch_en;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    address      = 6'h00;
    data_in      = 32'h0;
    data_write_n = 2'b11;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    address = a; data_in = d; data_write_n = 2'b10;
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  // Full LO+HI load with cycle-by-cycle expectations; optional clear in the DONE cycle.
  task automatic run_load(input logic [31:0] lo, input logic [31:0] hi,
                          input logic [3:0] exp_cnt, input bit clr_at_done);
    logic [7:0]  e;
    logic [63:0] cfg;
    cfg = {hi, lo};
    wr(6'h08, lo);
    wr(6'h0C, hi);
    for (int i = 1; i <= 17; i++) begin
      e = 8'h00;
      if ((i % 2 == 1) && i <= 15) e = 8'h01 << (7 - (i - 1) / 2);
      chk($sformatf("seq_en_c%0d", i), 64'(latch_en), 64'(e));
      chk($sformatf("seq_busy_c%0d", i), 64'(busy), 64'(i <= 16));
      chk($sformatf("seq_done_c%0d", i), 64'(done), 64'(i == 17));
      chk($sformatf("seq_cfg_c%0d", i), config_data, cfg);
      if (i == 17 && clr_at_done) clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
    end
    chk("seq_count", 64'(load_count), 64'(exp_cnt));
  endtask

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] dat;
    logic [1:0]  wn;
    logic        clr;
    logic        exp_err;
    logic [63:0] exp_cfg;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{6'h00, 32'h0,         2'b11, 1'b1, 1'b0, 64'h0};
    vecs[1] = '{6'h08, 32'hAAAA_AAAA, 2'b00, 1'b0, 1'b0, 64'h0};
    vecs[2] = '{6'h0C, 32'hBBBB_BBBB, 2'b01, 1'b0, 1'b0, 64'h0};
    vecs[3] = '{6'h08, 32'hCCCC_CCCC, 2'b01, 1'b0, 1'b0, 64'h0};
    vecs[4] = '{6'h0C, 32'hDDDD_DDDD, 2'b10, 1'b0, 1'b1, 64'h0};
    vecs[5] = '{6'h00, 32'h0,         2'b11, 1'b1, 1'b0, 64'h0};
    vecs[6] = '{6'h10, 32'hEEEE_EEEE, 2'b10, 1'b0, 1'b0, 64'h0};
    vecs[7] = '{6'h08, 32'h1111_2222, 2'b10, 1'b0, 1'b0, 64'h0000_0000_1111_2222};
    vecs[8] = '{6'h08, 32'h5555_6666, 2'b10, 1'b0, 1'b0, 64'h0000_0000_5555_6666};

    rst = 1'b1;
    clear = 1'b0;
    bus_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cfg", config_data, 64'h0);
    chk("rst_en", 64'(latch_en), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    chk("rst_cnt", 64'(load_count), 64'h0);
    #2 rst = 1'b0;

    // Single-write vectors; rows 1-4 prove narrow writes never set lo_valid.
    for (int v = 0; v < 9; v++) begin
      @(posedge clk); #1;
      address = vecs[v].addr; data_in = vecs[v].dat;
      data_write_n = vecs[v].wn; clear = vecs[v].clr;
      @(posedge clk); #1;
      bus_idle(); clear = 1'b0;
      chk($sformatf("vec%0d_err", v), 64'(err), 64'(vecs[v].exp_err));
      chk($sformatf("vec%0d_busy", v), 64'(busy), 64'h0);
      chk($sformatf("vec%0d_cfg", v), config_data, vecs[v].exp_cfg);
    end

    // Basic load.
    run_load(32'h1111_2222, 32'h3333_4444, 4'd1, 1'b0);
    chk("basic_err", 64'(err), 64'h0);

    // LO write mid-sequence is dropped and flagged.
    wr(6'h08, 32'h0BAD_0001);
    wr(6'h0C, 32'h0BAD_0002);
    repeat (3) begin @(posedge clk); #1; end
    address = 6'h08; data_in = 32'hDEAD_BEEF; data_write_n = 2'b10;
    @(posedge clk); #1;
    bus_idle();
    chk("mid_cfg", config_data, 64'h0BAD_0002_0BAD_0001);
    chk("mid_busy", 64'(busy), 64'h1);
    chk("mid_err", 64'(err), 64'h1);
    for (int n = 0; n < 40 && !done; n++) begin @(posedge clk); #1; end
    chk("mid_done_seen", 64'(done), 64'h1);
    chk("mid_cfg_end", config_data, 64'h0BAD_0002_0BAD_0001);
    @(posedge clk); #1;
    chk("mid_cnt", 64'(load_count), 64'd2);
    chk("mid_err_sticky", 64'(err), 64'h1);
    pulse_clear();
    chk("clr_err", 64'(err), 64'h0);
    chk("clr_cnt", 64'(load_count), 64'h0);

    // Saturation at DEPTH.
    for (int k = 0; k < 9; k++) begin
      run_load(32'h1000_0000 + 32'(k), 32'h2000_0000 + 32'(k), (k < 8) ? 4'(k + 1) : 4'd8, 1'b0);
    end

    // Clear coinciding with DONE wins over the increment.
    run_load(32'hA5A5_0000, 32'h5A5A_0000, 4'd0, 1'b1);

    // Asynchronous reset during the latch_en[4] pulse.
    wr(6'h08, 32'h7777_0000);
    wr(6'h0C, 32'h8888_0000);
    repeat (6) begin @(posedge clk); #1; end
    chk("arst_pre_en", 64'(latch_en), 64'h10);
    #2 rst = 1'b1;
    #1;
    chk("arst_en", 64'(latch_en), 64'h0);
    chk("arst_busy", 64'(busy), 64'h0);
    chk("arst_done", 64'(done), 64'h0);
    chk("arst_cfg", config_data, 64'h0);
    chk("arst_err", 64'(err), 64'h0);
    chk("arst_cnt", 64'(load_count), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_load(32'h9999_AAAA, 32'hBBBB_CCCC, 4'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prism_cfg_sequencer.md
Name: prism_cfg_sequencer

Overview:
Register-bus controller that loads 64-bit PRISM configuration words into the DEPTH-stage latch shift register.
- Two 32-bit bus writes (low half, then high half) are assembled into one 64-bit word.
- The word is then shifted into the latch chain using a glitch-free enable sequence: one-hot, registered, non-overlapping enables, walked from the last stage down to the first.
- Sits between the peripheral register decode and the latch array; reports busy, completion, sequencing errors and a count of words loaded.

Parameters:
DEPTH, 8, number of latch stages (one latch_en bit per stage)
WIDTH, 64, config word width; fixed at 2x32
LO_ADDR, 6'h08, address of the low-half write
HI_ADDR, 6'h0C, address of the high-half write (triggers the load)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
address  input  6  peripheral register address
data_in  input  32  bus write data
data_write_n  input  2  11 = no write, 00 = 8-bit, 01 = 16-bit, 10 = 32-bit
clear  input  1  synchronous soft clear of the status state
config_data  output  WIDTH  assembled word {hi, lo} driven to all latch D inputs
latch_en  output  DEPTH  one-hot latch enables, registered, never overlapping
busy  output  1  load sequence in progress
done  output  1  one-cycle pulse at the end of a sequence
err  output  1  sticky sequencing error
load_count  output  $clog2(DEPTH)+1  words loaded since reset/clear, saturates at DEPTH

Behaviour:
- Reset (rst high, asynchronous): state IDLE; lo_valid=0; config_data=0; latch_en=0; busy=0; done=0; err=0; load_count=0. latch_en drops to 0 immediately on assertion, including mid-sequence; a partial load is abandoned.
- Only 32-bit writes (data_write_n==2'b10) to LO_ADDR/HI_ADDR are accepted. 8-bit and 16-bit writes to those addresses are ignored silently; err is not set.
- LO write in IDLE: config_data[31:0] <= data_in; lo_valid <= 1. A repeated LO write overwrites and keeps lo_valid=1.
- HI write in IDLE with lo_valid=1, sampled at edge T:
  - config_data[63:32] <= data_in; lo_valid <= 0; enter PULSE with idx=DEPTH-1.
- HI write in IDLE with lo_valid=0: ignored; err <= 1.
- Any accepted LO/HI write while busy: dropped; err <= 1; config_data is unchanged.
- State machine IDLE -> PULSE -> GAP -> (PULSE | DONE) -> IDLE:
  - PULSE: latch_en = 1 << idx for exactly one cycle.
  - GAP: latch_en = 0 for one cycle. If idx==0, go to DONE; otherwise idx <= idx-1 and return to PULSE.
  - DONE: one cycle; done=1, busy=0, latch_en=0; then IDLE.
- Timing for a start at edge T:
  - busy=1 for cycles T+1 .. T+2*DEPTH.
  - latch_en[k] is high only in cycle T+1+2*(DEPTH-1-k).
  - done is high in cycle T+2*DEPTH+1.
  - Next start accepted at the earliest by an HI write sampled at the DONE cycle edge.
- config_data is stable from T+1 until the next accepted write; it never changes while any latch_en is high.
- latch_en, busy and done come straight from flops, with no combinational decode on the outputs.
- load_count increments by 1 in the DONE cycle and saturates at DEPTH.
- clear: err<=0, load_count<=0, lo_valid<=0. It does not abort a running sequence. If clear coincides with DONE, clear wins and load_count ends at 0.
- The same-cycle error-set and clear conflict resolves to err=0; clear has priority.

Decomposition:
- Package prism_cfg_pkg: state enum (IDLE, PULSE, GAP, DONE), LO_ADDR/HI_ADDR constants, data_write_n encodings.
- Single module, no sub-module: the sequencer is a small FSM plus a down-counter.

Test Plan:
- Write LO=32'h1111_2222, HI=32'h3333_4444 (32-bit each) -> config_data=64'h3333_4444_1111_2222; busy for 16 cycles; latch_en seen as 0x80, 0, 0x40, 0, ..., 0x01, 0; done for 1 cycle; load_count=1.
- Load 8 words, then a 9th -> load_count saturates at 8; latch_en never has more than one bit set in any cycle; at least one zero cycle between enables.
- HI write with no prior LO -> no busy; err=1; assert clear -> err=0.
- LO write mid-sequence (cycle 5 of busy) -> config_data unchanged; sequence completes; err=1.
- 8-bit and 16-bit writes to 0x08/0x0C -> ignored; lo_valid stays 0; err stays 0.
- Assert rst during the latch_en[4] pulse -> latch_en=0 in the same cycle, asynchronously; all outputs at reset values; next LO+HI pair loads normally.
